gray_codec: RTL and testbench

//   Parametrised, registered binary<->Gray converter with a per-word direction select.

---
 rtl/gray_codec.sv | 155 +++++++++++++++
 tb/tb_gray_codec.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_codec.sv
// gray_codec: registered binary<->Gray converter with a per-word direction
// select, valid/ready handshakes on both sides and a 2-entry output buffer.
// Optional macro GRAY_STEP_CHECK_EN adds the step_err output, which flags
// mode-1 (Gray) input words that do not differ from the previous mode-1
// word in exactly one bit.
//
// Handshake: a word moves across an interface on a rising clk edge where
// that interface's valid and ready are both high. Valid never depends on
// ready in the same cycle, and an offered output word holds steady until
// it is taken.
module gray_codec #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode
`ifdef GRAY_STEP_CHECK_EN
  ,
  output logic             step_err
`endif
);

  // Buffer layout: the head slot feeds out_* directly, and the tail slot
  // is used only when two words are held. Because the head is a dedicated
  // register, out_data and out_mode keep their last value when the buffer
  // drains.
  logic [WIDTH-1:0] r_head_data;
  logic             r_head_mode;
  logic [WIDTH-1:0] r_tail_data;
  logic             r_tail_mode;
  logic [1:0]       r_count;
  logic             r_in_ready;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;
  logic [WIDTH-1:0] w_conv;

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    g[WIDTH-1] = b[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      g[i] = b[i+1] ^ b[i];
    end
    return g;
  endfunction

  // Each output bit is the XOR of all Gray bits from the MSB down to it.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign w_push    = in_valid & r_in_ready;
  assign w_pop     = (r_count != 2'd0) & out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_head_data;
  assign out_mode  = r_head_mode;

  // Convert the incoming word in the direction it carries.
  always_comb begin
    w_conv = in_mode ? gray_to_bin(in_data) : bin_to_gray(in_data);
  end

  // Next occupancy. A push into a full buffer cannot happen because
  // in_ready is low whenever the count is 2.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Occupancy and the registered in_ready. in_ready is derived from the
  // next count, so a pop from full raises it in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
    end
  end

  // Buffer slots. With one word held, a simultaneous push and pop writes
  // the new word straight into the head. A pop from two words moves the
  // tail into the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_data <= '0;
      r_head_mode <= 1'b0;
      r_tail_data <= '0;
      r_tail_mode <= 1'b0;
    end else begin
      if (w_push && ((r_count == 2'd0) || (r_count == 2'd1 && w_pop))) begin
        r_head_data <= w_conv;
        r_head_mode <= in_mode;
      end else if (w_pop && r_count == 2'd2) begin
        r_head_data <= r_tail_data;
        r_head_mode <= r_tail_mode;
      end
      if (w_push && r_count == 2'd1 && !w_pop) begin
        r_tail_data <= w_conv;
        r_tail_mode <= in_mode;
      end
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] r_prev;
  logic             r_have_prev;
  logic             r_step_err;
  logic [WIDTH-1:0] w_diff;
  logic             w_one_bit;

  // The words differ in exactly one bit when their XOR is a non-zero
  // power of two. Identical words give zero and so count as an error.
  assign w_diff    = in_data ^ r_prev;
  assign w_one_bit = (w_diff != '0) && ((w_diff & (w_diff - 1'b1)) == '0);
  assign step_err  = r_step_err;

  // Track the last accepted Gray word and pulse step_err for one cycle
  // on a bad step. Mode-0 words leave this state alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_step_err  <= 1'b0;
    end else begin
      r_step_err <= 1'b0;
      if (w_push && in_mode) begin
        r_prev      <= in_data;
        r_have_prev <= 1'b1;
        r_step_err  <= r_have_prev && !w_one_bit;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gray_codec.sv
// Testbench for gray_codec (WIDTH=4): table-driven conversion vectors,
// exhaustive round trip, backpressure, streaming, reset and step check.
module tb_gray_codec;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_mode;
`ifdef GRAY_STEP_CHECK_EN
  logic         step_err;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         mode;
    logic [W-1:0] data;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  gray_codec #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
`ifdef GRAY_STEP_CHECK_EN
    ,
    .step_err  (step_err)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] m_b2g(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = 0; i < W - 1; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Send one word with out_ready high and check it appears one edge later.
  task automatic send_one(input logic mode, input logic [W-1:0] data, input logic [W-1:0] exp,
                          input string name);
    in_valid  = 1'b1;
    in_mode   = mode;
    in_data   = data;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, 32'(out_data), 32'(exp));
    check({name, "_mode"}, 32'(out_mode), 32'(mode));
  endtask

  logic [W-1:0] g_tmp;
  logic [W-1:0] a_w, b_w, c_w;

  initial begin
    // Directed table: hand-computed conversions.
    vecs[0]  = '{1'b0, 4'b1011, 4'b1110};
    vecs[1]  = '{1'b1, 4'b1110, 4'b1011};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0000};
    vecs[3]  = '{1'b0, 4'b0010, 4'b0011};
    vecs[4]  = '{1'b0, 4'b0111, 4'b0100};
    vecs[5]  = '{1'b0, 4'b1000, 4'b1100};
    vecs[6]  = '{1'b0, 4'b1111, 4'b1000};
    vecs[7]  = '{1'b1, 4'b1000, 4'b1111};
    vecs[8]  = '{1'b1, 4'b0100, 4'b0111};
    vecs[9]  = '{1'b1, 4'b1100, 4'b1000};
    vecs[10] = '{1'b1, 4'b0011, 4'b0010};
    vecs[11] = '{1'b1, 4'b1111, 4'b1010};

    // Reset state.
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_mode", 32'(out_mode), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table vectors, back to back (push+pop at count 1).
    for (int i = 0; i < 12; i++) begin
      send_one(vecs[i].mode, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));
    end
    tick();
    check("drain_empty", 32'(out_valid), 32'd0);
    check("empty_hold_data", 32'(out_data), 32'(vecs[11].exp));
    check("empty_hold_mode", 32'(out_mode), 32'd1);

    // Exhaustive round trip.
    for (int b = 0; b < 16; b++) begin
      send_one(1'b0, W'(b), m_b2g(W'(b)), $sformatf("sweep_fwd%0d", b));
      g_tmp = out_data;
      send_one(1'b1, g_tmp, W'(b), $sformatf("sweep_back%0d", b));
    end
    in_valid = 1'b0;
    tick();

    // Backpressure: A,B buffered, C held, then drained in order.
    a_w = 4'b0101; b_w = 4'b1001; c_w = 4'b1110;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_data   = a_w;
    tick();
    check("bp_a_ready", 32'(in_ready), 32'd1);
    check("bp_a_valid", 32'(out_valid), 32'd1);
    check("bp_a_head", 32'(out_data), 32'(m_b2g(a_w)));
    in_data = b_w;
    tick();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_full_head", 32'(out_data), 32'(m_b2g(a_w)));
    in_data = c_w;
    tick();
    check("bp_hold_ready", 32'(in_ready), 32'd0);
    check("bp_hold_head", 32'(out_data), 32'(m_b2g(a_w)));
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_b_head", 32'(out_data), 32'(m_b2g(b_w)));
    check("bp_b_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_c_valid", 32'(out_valid), 32'd1);
    check("bp_c_head", 32'(out_data), 32'(m_b2g(c_w)));
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Streaming: 16 words, one per cycle, latency 1.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_mode  = 1'b0;
      in_data  = W'(15 - i);
      exp_q.push_back(m_b2g(W'(15 - i)));
      tick();
      check($sformatf("stream_ready%0d", i), 32'(in_ready), 32'd1);
      check($sformatf("stream_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("stream_data%0d", i), 32'(out_data), 32'(exp_q.pop_front()));
    end
    in_valid = 1'b0;
    tick();
    check("stream_end", 32'(out_valid), 32'd0);
    check("stream_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-operation with two words buffered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_data   = 4'b0110;
    tick();
    in_data = 4'b0011;
    tick();
    in_valid = 1'b0;
    check("pre_rst_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_data", 32'(out_data), 32'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("postrst_empty", 32'(out_valid), 32'd0);
    tick();
    check("postrst_empty2", 32'(out_valid), 32'd0);
    send_one(1'b1, 4'b0110, 4'b0100, "postrst_first");
    tick();

`ifdef GRAY_STEP_CHECK_EN
    // Step check after a fresh reset.
    do_reset();
    send_one(1'b1, 4'b0000, 4'b0000, "step0");
    check("step_err0", 32'(step_err), 32'd0);
    send_one(1'b1, 4'b0001, 4'b0001, "step1");
    check("step_err1", 32'(step_err), 32'd0);
    send_one(1'b0, 4'b1111, 4'b1000, "step_m0");
    check("step_err_m0", 32'(step_err), 32'd0);
    send_one(1'b1, 4'b0011, 4'b0010, "step2");
    check("step_err2", 32'(step_err), 32'd0);
    send_one(1'b1, 4'b0111, 4'b0101, "step3");
    check("step_err3", 32'(step_err), 32'd0);
    send_one(1'b1, 4'b0100, 4'b0111, "step4");
    check("step_err4", 32'(step_err), 32'd1);
    send_one(1'b1, 4'b0100, 4'b0111, "step5");
    check("step_err5", 32'(step_err), 32'd1);
    tick();
    check("step_err_pulse_end", 32'(step_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
